// File: rtl/stepper_ctrl_if.sv
// Command, jog and status bundle for the stepper controller.
// The master modport drives commands; the slave modport is the controller side.
interface stepper_ctrl_if #(
  parameter int P_POS_W = 16,
  parameter int P_DIV_W = 24
);
  logic [P_DIV_W-1:0] i_period;
  logic               i_half;
  logic               i_cmd_valid;
  logic [P_POS_W-1:0] i_cmd_target;
  logic               o_cmd_ready;
  logic               i_jog_fwd;
  logic               i_jog_rev;
  logic               i_stop;
  logic [3:0]         o_coil;
  logic [P_POS_W-1:0] o_pos;
  logic               o_busy;
  logic               o_done;
  logic               o_abort;
  logic               o_at_min;
  logic               o_at_max;

  modport master (
    output i_period, i_half, i_cmd_valid, i_cmd_target, i_jog_fwd, i_jog_rev, i_stop,
    input  o_cmd_ready, o_coil, o_pos, o_busy, o_done, o_abort, o_at_min, o_at_max
  );

  modport slave (
    input  i_period, i_half, i_cmd_valid, i_cmd_target, i_jog_fwd, i_jog_rev, i_stop,
    output o_cmd_ready, o_coil, o_pos, o_busy, o_done, o_abort, o_at_min, o_at_max
  );
endinterface

// File: rtl/stepper_ctrl.sv
// Unipolar stepper controller: absolute moves and manual jog within [0, P_POS_MAX],
// half- or full-step coil sequencing, programmable step period.
module stepper_ctrl #(
  parameter int P_POS_W   = 16,
  parameter int P_POS_MAX = 400,
  parameter int P_DIV_W   = 24
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  stepper_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_JOG  = 2'd2;

  localparam logic [P_POS_W-1:0] POS_MAX = P_POS_W'(P_POS_MAX);
  localparam logic [P_DIV_W-1:0] DIV_ONE = P_DIV_W'(1);

  logic [1:0]         state;
  logic [P_POS_W-1:0] pos;
  logic [P_POS_W-1:0] target;
  logic [P_DIV_W-1:0] div;
  logic               done;
  logic               abort;

  logic [P_DIV_W-1:0] period_eff;
  logic               tick;
  logic               jog_one;
  logic               move_fwd;
  logic               dir_fwd;
  logic [1:0]         inc;
  logic [1:0]         step;
  logic [P_POS_W-1:0] room;
  logic [P_POS_W-1:0] pos_next;
  logic [3:0]         coil;

  function automatic logic [P_POS_W-1:0] clamp_target(input logic [P_POS_W-1:0] t);
    return (t > POS_MAX) ? POS_MAX : t;
  endfunction

  // Shrinks an increment so it lands exactly on the limit/target instead of crossing it.
  function automatic logic [1:0] limit_step(input logic [1:0] want,
                                            input logic [P_POS_W-1:0] avail);
    return (avail < P_POS_W'(want)) ? avail[1:0] : want;
  endfunction

  always_comb begin
    period_eff = (bus.i_period == '0) ? DIV_ONE : bus.i_period;
    // >= rather than == so a period shortened mid-move still ticks promptly
    tick       = (div >= period_eff - DIV_ONE);
    jog_one    = bus.i_jog_fwd ^ bus.i_jog_rev;
    move_fwd   = (target > pos);
    dir_fwd    = (state == S_MOVE) ? move_fwd : bus.i_jog_fwd;
    inc        = (bus.i_half || pos[0]) ? 2'd1 : 2'd2;
    if (state == S_MOVE)
      room = move_fwd ? (target - pos) : (pos - target);
    else
      room = bus.i_jog_fwd ? (POS_MAX - pos) : pos;
    step     = limit_step(inc, room);
    pos_next = dir_fwd ? (pos + P_POS_W'(step)) : (pos - P_POS_W'(step));
  end

  always_comb begin
    coil = 4'b1100;
    case (pos[2:0])
      3'd0: coil = 4'b1100;
      3'd1: coil = 4'b0100;
      3'd2: coil = 4'b0110;
      3'd3: coil = 4'b0010;
      3'd4: coil = 4'b0011;
      3'd5: coil = 4'b0001;
      3'd6: coil = 4'b1001;
      3'd7: coil = 4'b1000;
      default: coil = 4'b1100;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      pos    <= '0;
      target <= '0;
      div    <= '0;
      done   <= 1'b0;
      abort  <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_cmd_valid) begin
            target <= clamp_target(bus.i_cmd_target);
            div    <= '0;
            state  <= S_MOVE;
          end else if (jog_one) begin
            div   <= '0;
            state <= S_JOG;
          end
        end
        S_MOVE: begin
          if (bus.i_stop) begin
            abort <= 1'b1;
            state <= S_IDLE;
          end else if (pos == target) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            div <= tick ? '0 : (div + DIV_ONE);
            if (tick) pos <= pos_next;
          end
        end
        S_JOG: begin
          if (bus.i_stop || !jog_one) begin
            state <= S_IDLE;
          end else begin
            div <= tick ? '0 : (div + DIV_ONE);
            if (tick) pos <= pos_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_cmd_ready = (state == S_IDLE);
  assign bus.o_busy      = (state != S_IDLE);
  assign bus.o_coil      = coil;
  assign bus.o_pos       = pos;
  assign bus.o_done      = done;
  assign bus.o_abort     = abort;
  assign bus.o_at_min    = (pos == '0);
  assign bus.o_at_max    = (pos == POS_MAX);

endmodule
